pll_scan_responder: RTL and testbench
=====================================

Name: pll_scan_responder

Overview:
- Synthesizable responder for the PLL dynamic-reconfiguration serial scan interface: the PLL-side end of the scanclk/scandata/scanclkena/configupdate/scandone/areset bus.
- Shifts in the serial chain, commits it as the active configuration on configupdate, and reports completion through scandone.
- Emulates the locked sequence and exposes the committed configuration word plus shift-count diagnostics.
- Used in place of the hard PLL in simulation and FPGA self-test builds, so the PAL/NTSC reconfiguration path can be exercised end to end.

Parameters:
- CHAIN_LEN, 144, scan chain length in bits (Cyclone III/IV PLL).
- DONE_DLY, 16, clk_i cycles from configupdate capture to scandone reassertion (1..255).
- LOCK_DLY, 64, clk_i cycles from areset release to locked (1..1023).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- scanclk  in  1  scan clock, generated synchronously from clk_i; high and low phases ≥1 clk_i cycle each.
- scanclkena  in  1  shift enable, sampled at scanclk rising edge.
- scandata  in  1  serial data, sampled at scanclk rising edge.
- configupdate  in  1  commit request, sampled at scanclk rising edge.
- areset  in  1  PLL reset, level sensitive.
- scandataout  out  1  serial readback (see Optional Feature).
- scandone  out  1  high = idle/complete, low = update in progress.
- locked  out  1  emulated PLL lock.
- cfg_word  out  CHAIN_LEN  committed configuration.
- cfg_valid  out  1  high once any configuration has been committed.
- cfg_pulse  out  1  one-cycle strobe when scandone reasserts.
- len_err  out  1  sticky: shift count ≠ CHAIN_LEN at the last commit.

Behaviour:
- Reset (async assert, clk_i-synchronous release) clears all state. Outputs during reset: scandataout=0, scandone=1, locked=0, cfg_word=0, cfg_valid=0, cfg_pulse=0, len_err=0.
- Edge detect: scanclk is registered once. A scan edge is the cycle where scanclk=1 and the registered copy=0. All scan-side sampling happens only on scan edges, using input values from that same cycle.
- Shift: on a scan edge with scanclkena=1, chain <= {chain[CHAIN_LEN-2:0], scandata}. shift_cnt increments and saturates at 255.
- FSM states: IDLE, UPDATE, LOCKWAIT, LOCKED.
- Commit (any state except UPDATE): on a scan edge with configupdate=1:
  - cfg_word <= chain, cfg_valid <= 1;
  - len_err <= (shift_cnt ≠ CHAIN_LEN);
  - shift_cnt <= 0; scandone <= 0; locked <= 0; delay counter <= DONE_DLY-1; go to UPDATE.
- Shift and commit on the same edge: the shift happens first, and the committed word includes the new bit. shift_cnt counts that bit before the comparison.
- configupdate while in UPDATE: ignored. Shifting continues.
- UPDATE: the counter decrements each cycle. When it reaches 0: scandone <= 1, cfg_pulse high for exactly one cycle, then go to LOCKWAIT with the lock counter <= LOCK_DLY-1.
- LOCKWAIT: the lock counter decrements while areset=0. When it reaches 0: locked <= 1, go to LOCKED.
- areset=1 in any state except UPDATE: locked <= 0, lock counter reloads, go to LOCKWAIT. The chain and cfg_word are preserved.
- areset=1 during UPDATE: recorded. When UPDATE finishes, the lock counter holds until areset falls.
- Latency: configupdate edge to scandone low = 1 clk_i cycle; scandone low duration = DONE_DLY cycles; scandone rise to locked = LOCK_DLY cycles (areset low).
- IDLE is left only by a commit or by areset. After reset the FSM sits in IDLE with locked=0 until the first commit or areset pulse.

Optional Feature:
- Macro: PLL_SCAN_READBACK_EN.
- Defined: scandataout = chain[CHAIN_LEN-1], registered, so a full CHAIN_LEN-bit shift returns the prior chain contents MSB-first.
- Undefined: scandataout is constant 0 and no readback logic is built.

Test Plan:
- Shift 144 bits of a pattern (bit i = i mod 3 == 0), then pulse configupdate → cfg_word matches the pattern; len_err=0; scandone low for 16 cycles; cfg_pulse once; locked high 64 cycles after scandone rises.
- Shift 143 bits, then commit → len_err=1 and stays 1; a subsequent correct 144-bit commit clears it to 0.
- Hold areset=1 for 10 cycles in LOCKED → locked=0 immediately; locked=1 exactly 64 cycles after areset falls; cfg_word unchanged.
- Issue a second configupdate during UPDATE → no effect on cfg_word or the counter; scandone rises at the original time.
- Assert reset_n=0 mid-shift and mid-UPDATE → all outputs at reset values in the same cycle; scandone=1, cfg_valid=0.
- With PLL_SCAN_READBACK_EN: commit pattern A (0xA5 repeated), then shift 144 zeros → scandataout reproduces pattern A MSB-first. Without the macro, scandataout stays 0.

Source files
------------

// File: rtl/pll_scan_responder.sv
// -----------------------------------------------------------------------------
// pll_scan_responder
//   PLL-side end of the dynamic-reconfiguration scan bus. It shifts the serial
//   chain in on scanclk rising edges and commits it as the active configuration
//   on configupdate. scandone is dropped for DONE_DLY cycles and the emulated
//   lock returns LOCK_DLY cycles after that. A simulation / self-test stand-in
//   for the hard PLL.
//
//   Optional build macro: PLL_SCAN_READBACK_EN
//     defined   : scandataout = chain MSB (register), serial readback
//     undefined : scandataout tied to 0, no readback logic
//
// Ports
//   clk_i         in   system clock, rising edge
//   reset_n       in   async active-low reset (release synchronised to clk_i)
//   scanclk       in   scan clock, synchronous to clk_i, phases >= 1 cycle
//   scanclkena    in   shift enable, sampled on scan edge
//   scandata      in   serial data, sampled on scan edge
//   configupdate  in   commit request, sampled on scan edge
//   areset        in   PLL reset, level sensitive
//   scandataout   out  serial readback
//   scandone      out  1 = idle/complete, 0 = update in progress
//   locked        out  emulated PLL lock
//   cfg_word      out  committed configuration word
//   cfg_valid     out  a configuration has been committed
//   cfg_pulse     out  one-cycle strobe when scandone reasserts
//   len_err       out  shift count differed from CHAIN_LEN at the last commit
// -----------------------------------------------------------------------------
module pll_scan_responder #(
  parameter int CHAIN_LEN = 144,
  parameter int DONE_DLY  = 16,
  parameter int LOCK_DLY  = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic                 scanclk,
  input  logic                 scanclkena,
  input  logic                 scandata,
  input  logic                 configupdate,
  input  logic                 areset,
  output logic                 scandataout,
  output logic                 scandone,
  output logic                 locked,
  output logic [CHAIN_LEN-1:0] cfg_word,
  output logic                 cfg_valid,
  output logic                 cfg_pulse,
  output logic                 len_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UPDATE   = 2'd1,
    ST_LOCKWAIT = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  localparam logic [7:0] DONE_LOAD = 8'(DONE_DLY - 1);
  localparam logic [9:0] LOCK_LOAD = 10'(LOCK_DLY - 1);

  logic [1:0]           rst_sync_q;
  logic                 rst_int_n;

  state_t               state_q,       state_d;
  logic                 scanclk_q;
  logic [CHAIN_LEN-1:0] chain_q,       chain_d;
  logic [7:0]           shift_cnt_q,   shift_cnt_d;
  logic [7:0]           dly_q,         dly_d;
  logic [9:0]           lock_q,        lock_d;
  logic [CHAIN_LEN-1:0] cfg_word_q,    cfg_word_d;
  logic                 cfg_valid_q,   cfg_valid_d;
  logic                 len_err_q,     len_err_d;
  logic                 scandone_q,    scandone_d;
  logic                 locked_q,      locked_d;
  logic                 cfg_pulse_q,   cfg_pulse_d;

  logic                 scan_edge_s;
  logic                 shift_en_s;
  logic                 commit_s;
  logic [CHAIN_LEN-1:0] chain_shift_s;
  logic [7:0]           cnt_after_s;

  // Reset synchroniser: asserts asynchronously, releases on clk_i.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Scan-edge detection and the commit condition (commit is refused in UPDATE).
  assign scan_edge_s   = scanclk & ~scanclk_q;
  assign shift_en_s    = scan_edge_s & scanclkena;
  assign commit_s      = scan_edge_s & configupdate & (state_q != ST_UPDATE);
  assign chain_shift_s = {chain_q[CHAIN_LEN-2:0], scandata};

  // Shift count including a bit shifted on this same edge, saturating at 255.
  always_comb begin
    cnt_after_s = shift_cnt_q;
    if (shift_en_s && (shift_cnt_q != 8'hFF)) begin
      cnt_after_s = shift_cnt_q + 8'd1;
    end else begin
      cnt_after_s = shift_cnt_q;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    chain_d     = chain_q;
    shift_cnt_d = cnt_after_s;
    dly_d       = dly_q;
    lock_d      = lock_q;
    cfg_word_d  = cfg_word_q;
    cfg_valid_d = cfg_valid_q;
    len_err_d   = len_err_q;
    scandone_d  = scandone_q;
    locked_d    = locked_q;
    cfg_pulse_d = 1'b0;

    if (shift_en_s) begin
      chain_d = chain_shift_s;
    end else begin
      chain_d = chain_q;
    end

    case (state_q)
      ST_UPDATE: begin
        // areset is not acted on here; LOCKWAIT holds the counter while it is high.
        if (dly_q == 8'd0) begin
          scandone_d  = 1'b1;
          cfg_pulse_d = 1'b1;
          lock_d      = LOCK_LOAD;
          state_d     = ST_LOCKWAIT;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      ST_IDLE, ST_LOCKWAIT, ST_LOCKED: begin
        if (commit_s) begin
          // Committed word already contains a bit shifted on this edge.
          cfg_word_d  = chain_d;
          cfg_valid_d = 1'b1;
          len_err_d   = ({24'd0, cnt_after_s} != 32'(CHAIN_LEN));
          shift_cnt_d = 8'd0;
          scandone_d  = 1'b0;
          locked_d    = 1'b0;
          dly_d       = DONE_LOAD;
          state_d     = ST_UPDATE;
        end else if (areset) begin
          locked_d = 1'b0;
          lock_d   = LOCK_LOAD;
          state_d  = ST_LOCKWAIT;
        end else if (state_q == ST_LOCKWAIT) begin
          if (lock_q == 10'd0) begin
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end else begin
            lock_d = lock_q - 10'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      scanclk_q   <= 1'b0;
      chain_q     <= '0;
      shift_cnt_q <= 8'd0;
      dly_q       <= 8'd0;
      lock_q      <= 10'd0;
      cfg_word_q  <= '0;
      cfg_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      scandone_q  <= 1'b1;
      locked_q    <= 1'b0;
      cfg_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scanclk_q   <= scanclk;
      chain_q     <= chain_d;
      shift_cnt_q <= shift_cnt_d;
      dly_q       <= dly_d;
      lock_q      <= lock_d;
      cfg_word_q  <= cfg_word_d;
      cfg_valid_q <= cfg_valid_d;
      len_err_q   <= len_err_d;
      scandone_q  <= scandone_d;
      locked_q    <= locked_d;
      cfg_pulse_q <= cfg_pulse_d;
    end
  end

  assign scandone  = scandone_q;
  assign cfg_word  = cfg_word_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_pulse = cfg_pulse_q;
  assign len_err   = len_err_q;
  // Lock drops in the same cycle areset rises, as a real PLL would.
  assign locked    = locked_q & ~areset;

`ifdef PLL_SCAN_READBACK_EN
  assign scandataout = chain_q[CHAIN_LEN-1];
`else
  assign scandataout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_scan_responder.sv
module tb_pll_scan_responder;

  localparam int CL = 144;
  localparam int DD = 16;
  localparam int LD = 64;

  logic          clk_i = 1'b0;
  logic          reset_n = 1'b0;
  logic          scanclk = 1'b0;
  logic          scanclkena = 1'b0;
  logic          scandata = 1'b0;
  logic          configupdate = 1'b0;
  logic          areset = 1'b0;
  logic          scandataout;
  logic          scandone;
  logic          locked;
  logic [CL-1:0] cfg_word;
  logic          cfg_valid;
  logic          cfg_pulse;
  logic          len_err;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  pll_scan_responder #(.CHAIN_LEN(CL), .DONE_DLY(DD), .LOCK_DLY(LD)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .scanclk(scanclk), .scanclkena(scanclkena),
    .scandata(scandata), .configupdate(configupdate), .areset(areset),
    .scandataout(scandataout), .scandone(scandone), .locked(locked),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_pulse(cfg_pulse), .len_err(len_err)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [CL-1:0] act, logic [CL-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model (event times, bit history) ----------------
  int  n, commit_n, lock_at, shifts;
  bit  have_commit, lock_armed, prev_sclk;
  bit  bits[$];
  logic [CL-1:0] e_cfg;
  bit  e_valid, e_lenerr;

  function automatic void model_clear();
    n = 0; commit_n = 0; lock_at = 0; shifts = 0;
    have_commit = 0; lock_armed = 0; prev_sclk = 0;
    bits.delete();
    e_cfg = '0; e_valid = 0; e_lenerr = 0;
  endfunction

  // Last CL shifted bits, newest at bit 0.
  function automatic logic [CL-1:0] chain_word();
    logic [CL-1:0] w;
    int sz;
    w = '0;
    sz = bits.size();
    for (int i = 0; i < sz; i++) w[i] = bits[sz-1-i];
    return w;
  endfunction

  function automatic void model_step();
    bit edge_s, busy;
    n++;
    edge_s = scanclk && !prev_sclk;
    prev_sclk = scanclk;
    busy = have_commit && (n > commit_n) && (n <= commit_n + DD);
    if (edge_s && scanclkena) begin
      bits.push_back(scandata);
      if (bits.size() > CL) void'(bits.pop_front());
      shifts++;
    end
    if (!busy && areset) begin
      lock_armed = 1;
      lock_at = n + LD;
    end
    if (edge_s && configupdate && !busy) begin
      have_commit = 1;
      commit_n = n;
      e_cfg = chain_word();
      e_valid = 1;
      e_lenerr = (shifts != CL);
      shifts = 0;
      lock_armed = 1;
      lock_at = n + DD + LD;
    end
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk_i or negedge reset_n);
      if (!reset_n) model_clear();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_en) begin
        bit e_done, e_pulse, e_lock, e_rb;
        e_done  = !(have_commit && n >= commit_n && n < commit_n + DD);
        e_pulse = have_commit && (n == commit_n + DD);
        e_lock  = lock_armed && (n >= lock_at) && !areset;
`ifdef PLL_SCAN_READBACK_EN
        e_rb    = (bits.size() == CL) ? bits[0] : 1'b0;
`else
        e_rb    = 1'b0;
`endif
        check("scandone",    CL'(scandone),    CL'(e_done));
        check("cfg_pulse",   CL'(cfg_pulse),   CL'(e_pulse));
        check("locked",      CL'(locked),      CL'(e_lock));
        check("cfg_word",    cfg_word,         e_cfg);
        check("cfg_valid",   CL'(cfg_valid),   CL'(e_valid));
        check("len_err",     CL'(len_err),     CL'(e_lenerr));
        check("scandataout", CL'(scandataout), CL'(e_rb));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scan_bit(input logic ena, input logic dat, input logic upd);
    scanclk = 1'b1; scanclkena = ena; scandata = dat; configupdate = upd;
    tick();
    scanclk = 1'b0; scanclkena = 1'b0; configupdate = 1'b0;
    tick();
  endtask

  // Commit edge, then measure scandone-low length, pulses and lock latency.
  task automatic commit_measure(input int second_at, output int low, output int pulses,
                                output int lockc);
    low = 0; pulses = 0; lockc = 0;
    scanclk = 1'b1; configupdate = 1'b1; scanclkena = 1'b0;
    tick();
    scanclk = 1'b0; configupdate = 1'b0;
    while (!scandone && low < 300) begin
      low++;
      if (cfg_pulse) pulses++;
      if (low == second_at) begin
        scanclk = 1'b1; configupdate = 1'b1; scanclkena = 1'b1; scandata = 1'b1;
      end else begin
        scanclk = 1'b0; configupdate = 1'b0; scanclkena = 1'b0;
      end
      tick();
    end
    scanclk = 1'b0; configupdate = 1'b0; scanclkena = 1'b0;
    while (!locked && lockc < 2000) begin
      if (cfg_pulse) pulses++;
      lockc++;
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    scanclk = 1'b0; scanclkena = 1'b0; configupdate = 1'b0; areset = 1'b0;
    #1;
    check("rst scandone", CL'(scandone), CL'(1'b1));
    check("rst cfg_valid", CL'(cfg_valid), CL'(1'b0));
    check("rst cfg_word", cfg_word, '0);
    check("rst locked", CL'(locked), CL'(1'b0));
    check("rst len_err", CL'(len_err), CL'(1'b0));
    check("rst cfg_pulse", CL'(cfg_pulse), CL'(1'b0));
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [CL-1:0] pat, pat_a, saved;
    int low, pulses, lockc;
    bit exp_rb;

    repeat (3) tick();
    chk_en = 1'b1;
    reset_n = 1'b1;
    repeat (4) tick();
    check("init scandone", CL'(scandone), CL'(1'b1));
    check("init locked", CL'(locked), CL'(1'b0));

    // Pattern: chain bit i = (i mod 3 == 0), shifted MSB first.
    for (int i = 0; i < CL; i++) pat[i] = ((i % 3) == 0);
    for (int i = CL - 1; i >= 0; i--) scan_bit(1'b1, pat[i], 1'b0);
    commit_measure(-1, low, pulses, lockc);
    check("pat cfg_word", cfg_word, pat);
    check("pat len_err", CL'(len_err), CL'(1'b0));
    check("pat done_low", CL'(low), CL'(DD));
    check("pat pulses", CL'(pulses), CL'(1));
    check("pat lock_lat", CL'(lockc), CL'(LD));

    // Short chain sets len_err, stays sticky, then a full chain clears it.
    for (int i = 0; i < CL - 1; i++) scan_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    commit_measure(-1, low, pulses, lockc);
    check("short len_err", CL'(len_err), CL'(1'b1));
    repeat (20) tick();
    check("short len_err sticky", CL'(len_err), CL'(1'b1));
    for (int i = 0; i < CL; i++) scan_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    commit_measure(-1, low, pulses, lockc);
    check("full len_err", CL'(len_err), CL'(1'b0));

    // areset for 10 cycles while locked.
    saved = cfg_word;
    areset = 1'b1;
    #1;
    check("areset locked drop", CL'(locked), CL'(1'b0));
    repeat (10) tick();
    areset = 1'b0;
    lockc = 0;
    while (!locked && lockc < 2000) begin lockc++; tick(); end
    check("areset relock", CL'(lockc), CL'(LD));
    check("areset cfg_word", cfg_word, saved);

    // Second configupdate during UPDATE is ignored.
    saved = cfg_word;
    commit_measure(4, low, pulses, lockc);
    check("dbl done_low", CL'(low), CL'(DD));
    check("dbl cfg_word", cfg_word, saved);
    check("dbl pulses", CL'(pulses), CL'(1));

    // Reset mid-shift and mid-UPDATE.
    for (int i = 0; i < 50; i++) scan_bit(1'b1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < CL; i++) scan_bit(1'b1, 1'b1, 1'b0);
    scanclk = 1'b1; configupdate = 1'b1;
    tick();
    scanclk = 1'b0; configupdate = 1'b0;
    repeat (5) tick();
    check("midupd scandone", CL'(scandone), CL'(1'b0));
    do_reset();

    // Readback: commit pattern A, then shift zeros.
    pat_a = {18{8'hA5}};
    for (int i = CL - 1; i >= 0; i--) scan_bit(1'b1, pat_a[i], 1'b0);
    commit_measure(-1, low, pulses, lockc);
    check("A cfg_word", cfg_word, pat_a);
    for (int k = 0; k < CL; k++) begin
`ifdef PLL_SCAN_READBACK_EN
      exp_rb = pat_a[CL-1-k];
`else
      exp_rb = 1'b0;
`endif
      if ((k % 8) == 0) check("readback", CL'(scandataout), CL'(exp_rb));
      scan_bit(1'b1, 1'b0, 1'b0);
    end

    // Randomised traffic checked by the model every cycle.
    for (int it = 0; it < 2500; it++) begin
      if (areset) begin
        if ($urandom_range(0, 9) < 3) areset = 1'b0;
      end else if ($urandom_range(0, 99) < 2) begin
        areset = 1'b1;
      end
      scanclk = 1'b1;
      scanclkena = ($urandom_range(0, 3) != 0);
      scandata = 1'($urandom_range(0, 1));
      configupdate = ($urandom_range(0, 59) == 0);
      tick();
      scanclk = 1'b0; scanclkena = 1'b0; configupdate = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    areset = 1'b0;
    repeat (100) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
